// File: rtl/j1_io_pkg.sv
// Shared address decode positions, status-word layout and helpers for the
// J1 IO-space UART hub.
package j1_io_pkg;

   localparam int ADDR_DATA_BIT = 12;
   localparam int ADDR_STAT_BIT = 13;
   localparam int ADDR_CH_LSB   = 8;
   localparam int ADDR_CH_MSB   = 9;

   localparam int ST_TX_NFULL   = 0;
   localparam int ST_RX_NEMPTY  = 1;
   localparam int ST_TX_EMPTY   = 2;
   localparam int ST_RX_OVF     = 3;
   localparam int ST_TX_OVF     = 4;
   localparam int ST_RXCNT_LSB  = 8;
   localparam int ST_TXCNT_LSB  = 16;
   localparam int RD_EMPTY_BIT  = 31;

   typedef struct packed {
      logic       tx_full;
      logic       tx_empty;
      logic       rx_empty;
      logic       rx_ovf;
      logic       tx_ovf;
      logic [7:0] rx_cnt;
      logic [7:0] tx_cnt;
   } chan_stat_t;

   function automatic logic [31:0] status_word(input chan_stat_t s);
      logic [31:0] w;
      w                        = 32'd0;
      w[ST_TX_NFULL]           = ~s.tx_full;
      w[ST_RX_NEMPTY]          = ~s.rx_empty;
      w[ST_TX_EMPTY]           = s.tx_empty;
      w[ST_RX_OVF]             = s.rx_ovf;
      w[ST_TX_OVF]             = s.tx_ovf;
      w[ST_RXCNT_LSB +: 8]     = s.rx_cnt;
      w[ST_TXCNT_LSB +: 8]     = s.tx_cnt;
      return w;
   endfunction

endpackage

// File: rtl/j1_sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero while empty so
// downstream data outputs stay quiet after reset.
module j1_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetq,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (count_r == {(AW+1){1'b0}});
   assign full      = (count_r == (AW+1)'(DEPTH));
   assign count     = count_r;
   assign do_pop_s  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push_s = push & (~full | do_pop_s);
   assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= wdata;
   end

endmodule

// File: rtl/j1_uart_hub.sv
// Multi-channel FIFO-buffered UART port block on the J1 IO bus: per-channel
// TX/RX FIFOs, status/overflow flags and a shared interrupt.
module j1_uart_hub
   import j1_io_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 16,
   parameter int DATA_W   = 8
) (
   input  logic                         clk,
   input  logic                         resetq,
   input  logic                         io_rd,
   input  logic                         io_wr,
   input  logic [15:0]                  io_addr,
   input  logic [31:0]                  io_wdata,
   output logic [31:0]                  io_din,
   output logic [CHANNELS-1:0]          tx_valid,
   output logic [CHANNELS*DATA_W-1:0]   tx_data,
   input  logic [CHANNELS-1:0]          tx_ready,
   input  logic [CHANNELS-1:0]          rx_valid,
   input  logic [CHANNELS*DATA_W-1:0]   rx_data,
   output logic [CHANNELS-1:0]          rx_ready,
   output logic                         irq
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic               io_rd_r;
   logic               io_wr_r;
   logic [15:0]        io_addr_r;
   logic [31:0]        io_wdata_r;
   logic               irq_r;
   logic [CHANNELS-1:0] rx_ovf_r;
   logic [CHANNELS-1:0] tx_ovf_r;

   logic [1:0]          ch_s;
   logic                sel_data_s;
   logic                sel_stat_s;
   logic [CHANNELS-1:0] cpu_sel_s;
   logic [CHANNELS-1:0] tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
   logic [CHANNELS-1:0] rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
   logic [CHANNELS-1:0] rx_ovf_set_s, tx_ovf_set_s, rx_ovf_clr_s, tx_ovf_clr_s;
   logic [CW-1:0]       tx_cnt_s   [CHANNELS];
   logic [CW-1:0]       rx_cnt_s   [CHANNELS];
   logic [DATA_W-1:0]   rx_head_s  [CHANNELS];
   logic [31:0]         data_word_s[CHANNELS];
   logic [31:0]         stat_word_s[CHANNELS];
   logic [31:0]         rd_word_s;
   logic                unused_s;

   assign ch_s       = io_addr_r[ADDR_CH_MSB:ADDR_CH_LSB];
   assign sel_data_s = io_addr_r[ADDR_DATA_BIT];
   assign sel_stat_s = io_addr_r[ADDR_STAT_BIT];
   assign unused_s   = ^{io_addr_r[15:14], io_addr_r[11:10], io_addr_r[7:0],
                         io_wdata_r[31:DATA_W]};

   // Bus front end: every side effect works on these registered copies.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         io_rd_r    <= 1'b0;
         io_wr_r    <= 1'b0;
         io_wdata_r <= 32'd0;
         io_addr_r  <= 16'd0;
      end else begin
         io_rd_r    <= io_rd;
         io_wr_r    <= io_wr;
         io_wdata_r <= io_wdata;
         if (io_rd | io_wr) io_addr_r <= io_addr;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      chan_stat_t st_s;

      // Unimplemented channel numbers never match, so they read 0 and ignore writes.
      assign cpu_sel_s[g]    = (ch_s == 2'(g));

      assign tx_push_s[g]    = io_wr_r & sel_data_s & cpu_sel_s[g];
      assign tx_pop_s[g]     = tx_ready[g] & ~tx_empty_s[g];
      assign tx_ovf_set_s[g] = tx_push_s[g] & tx_full_s[g] & ~tx_pop_s[g];

      assign rx_push_s[g]    = rx_valid[g];
      assign rx_pop_s[g]     = io_rd_r & sel_data_s & cpu_sel_s[g] & ~rx_empty_s[g];
      assign rx_ovf_set_s[g] = rx_push_s[g] & rx_full_s[g] & ~rx_pop_s[g];

      assign rx_ovf_clr_s[g] = io_wr_r & sel_stat_s & cpu_sel_s[g] & io_wdata_r[ST_RX_OVF];
      assign tx_ovf_clr_s[g] = io_wr_r & sel_stat_s & cpu_sel_s[g] & io_wdata_r[ST_TX_OVF];

      j1_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
         .clk   (clk),
         .resetq(resetq),
         .push  (tx_push_s[g]),
         .pop   (tx_pop_s[g]),
         .wdata (io_wdata_r[DATA_W-1:0]),
         .full  (tx_full_s[g]),
         .empty (tx_empty_s[g]),
         .count (tx_cnt_s[g]),
         .head  (tx_data[g*DATA_W +: DATA_W])
      );

      j1_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
         .clk   (clk),
         .resetq(resetq),
         .push  (rx_push_s[g]),
         .pop   (rx_pop_s[g]),
         .wdata (rx_data[g*DATA_W +: DATA_W]),
         .full  (rx_full_s[g]),
         .empty (rx_empty_s[g]),
         .count (rx_cnt_s[g]),
         .head  (rx_head_s[g])
      );

      assign tx_valid[g] = ~tx_empty_s[g];
      assign rx_ready[g] = ~rx_full_s[g];

      assign st_s.tx_full  = tx_full_s[g];
      assign st_s.tx_empty = tx_empty_s[g];
      assign st_s.rx_empty = rx_empty_s[g];
      assign st_s.rx_ovf   = rx_ovf_r[g];
      assign st_s.tx_ovf   = tx_ovf_r[g];
      assign st_s.rx_cnt   = 8'(rx_cnt_s[g]);
      assign st_s.tx_cnt   = 8'(tx_cnt_s[g]);

      assign stat_word_s[g] = status_word(st_s);
      assign data_word_s[g] = {rx_empty_s[g], {(31-DATA_W){1'b0}}, rx_head_s[g]};
   end

   // Read mux; both select bits set returns the OR of data and status words.
   always_comb begin
      rd_word_s = 32'd0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (cpu_sel_s[c]) begin
            if (sel_data_s) begin
               rd_word_s = rd_word_s | data_word_s[c];
            end else begin
               rd_word_s = rd_word_s;
            end
            if (sel_stat_s) begin
               rd_word_s = rd_word_s | stat_word_s[c];
            end else begin
               rd_word_s = rd_word_s;
            end
         end else begin
            rd_word_s = rd_word_s;
         end
      end
   end

   assign io_din = rd_word_s;

   // Sticky overflow flags; a new overflow beats a same-cycle clear.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_ovf_r <= {CHANNELS{1'b0}};
         tx_ovf_r <= {CHANNELS{1'b0}};
      end else begin
         rx_ovf_r <= rx_ovf_set_s | (rx_ovf_r & ~rx_ovf_clr_s);
         tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~tx_ovf_clr_s);
      end
   end

   // Interrupt request register.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= |(~rx_empty_s | rx_ovf_r | tx_ovf_r);
      end
   end

   assign irq = irq_r;

endmodule

// File: tb/tb_j1_uart_hub.sv
// Directed bench for j1_uart_hub: table-driven CPU accesses plus hand-written
// multi-cycle sequences for overflow, same-cycle and reset corner cases.
module tb_j1_uart_hub;

   logic        clk;
   logic        resetq;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] io_addr;
   logic [31:0] io_wdata;
   logic [31:0] io_din;
   logic [1:0]  tx_valid;
   logic [15:0] tx_data;
   logic [1:0]  tx_ready;
   logic [1:0]  rx_valid;
   logic [15:0] rx_data;
   logic [1:0]  rx_ready;
   logic        irq;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [0:9];

   j1_uart_hub #(.CHANNELS(2), .DEPTH(16), .DATA_W(8)) dut (
      .clk     (clk),
      .resetq  (resetq),
      .io_rd   (io_rd),
      .io_wr   (io_wr),
      .io_addr (io_addr),
      .io_wdata(io_wdata),
      .io_din  (io_din),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .rx_valid(rx_valid),
      .rx_data (rx_data),
      .rx_ready(rx_ready),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
      io_wr    = 1'b1;
      io_addr  = a;
      io_wdata = d;
      @(posedge clk); #1;
      io_wr    = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [31:0] d);
      io_rd   = 1'b1;
      io_addr = a;
      @(posedge clk); #1;
      io_rd   = 1'b0;
      d       = io_din;
   endtask

   task automatic run_table(input int first, input int last);
      logic [31:0] rd;
      for (int i = first; i <= last; i++) begin
         if (tbl[i].wr) begin
            cpu_write(tbl[i].addr, tbl[i].wdata);
         end else begin
            cpu_read(tbl[i].addr, rd);
            check($sformatf("tbl[%0d] rd %h", i, tbl[i].addr), rd, tbl[i].exp);
         end
      end
   endtask

   initial begin
      logic [31:0] rd;

      // ch1 RX reads, combined decode, absent channel 3, then ch0 status guard
      tbl[0] = '{1'b0, 16'h2100, 32'h0, 32'h0000_0207};
      tbl[1] = '{1'b0, 16'h1100, 32'h0, 32'h0000_0011};
      tbl[2] = '{1'b0, 16'h1100, 32'h0, 32'h0000_0022};
      tbl[3] = '{1'b0, 16'h1100, 32'h0, 32'h8000_0000};
      tbl[4] = '{1'b0, 16'h3100, 32'h0, 32'h8000_0005};
      tbl[5] = '{1'b0, 16'h1300, 32'h0, 32'h0000_0000};
      tbl[6] = '{1'b0, 16'h2300, 32'h0, 32'h0000_0000};
      tbl[7] = '{1'b1, 16'h1300, 32'h0000_0077, 32'h0};
      tbl[8] = '{1'b1, 16'h2300, 32'h0000_0018, 32'h0};
      tbl[9] = '{1'b0, 16'h2000, 32'h0, 32'h0010_0010};

      resetq = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0; io_wdata = 32'h0;
      tx_ready = 2'b00; rx_valid = 2'b00; rx_data = 16'h0;
      #1 resetq = 1'b0;
      #2;
      check("rst tx_valid", 32'(tx_valid), 32'h0);
      check("rst rx_ready", 32'(rx_ready), 32'h3);
      check("rst irq", 32'(irq), 32'h0);
      check("rst io_din", io_din, 32'h0);
      check("rst tx_data", 32'(tx_data), 32'h0);
      repeat (2) @(negedge clk);
      resetq = 1'b1;
      @(posedge clk); #1;

      cpu_read(16'h2000, rd);
      check("status ch0 after reset", rd, 32'h0000_0005);

      // TX on ch1 held, then drained back-to-back
      cpu_write(16'h1100, 32'h41);
      cpu_write(16'h1100, 32'h42);
      cpu_read(16'h2100, rd);
      check("ch1 status tx cnt 2", rd, 32'h0002_0001);
      check("ch1 tx_valid", 32'(tx_valid), 32'h2);
      check("ch1 tx head", 32'(tx_data[15:8]), 32'h41);
      tx_ready = 2'b10;
      @(negedge clk);
      check("drain 1st", {tx_valid[1], 23'd0, tx_data[15:8]}, 32'h8000_0041);
      @(negedge clk);
      check("drain 2nd", {tx_valid[1], 23'd0, tx_data[15:8]}, 32'h8000_0042);
      @(negedge clk);
      check("drained tx_valid", 32'(tx_valid), 32'h0);
      tx_ready = 2'b00;

      // Single RX byte on ch0 and irq timing
      rx_valid = 2'b01; rx_data = 16'h0055;
      @(posedge clk); #1;
      rx_valid = 2'b00;
      check("irq one cycle after push", 32'(irq), 32'h0);
      @(posedge clk); #1;
      check("irq two cycles after push", 32'(irq), 32'h1);
      cpu_read(16'h1000, rd);
      check("rx ch0 byte", rd, 32'h0000_0055);
      cpu_read(16'h1000, rd);
      check("rx ch0 empty", rd, 32'h8000_0000);
      @(posedge clk); #1;
      check("irq drops", 32'(irq), 32'h0);

      // Two RX bytes on ch1, then table-driven reads
      rx_valid = 2'b10; rx_data = 16'h1100;
      @(posedge clk); #1;
      rx_data = 16'h2200;
      @(posedge clk); #1;
      rx_valid = 2'b00;
      run_table(0, 4);

      // RX overflow on ch0
      for (int i = 0; i < 17; i++) begin
         rx_valid = 2'b01; rx_data = 16'(8'h60 + i);
         @(posedge clk); #1;
      end
      rx_valid = 2'b00;
      check("rx_ready ch0 full", 32'(rx_ready), 32'h2);
      cpu_read(16'h2000, rd);
      check("ch0 rx ovf status", rd, 32'h0000_100F);
      cpu_write(16'h2000, 32'h08);
      cpu_read(16'h2000, rd);
      check("ch0 rx ovf cleared", rd, 32'h0000_1007);
      cpu_write(16'h2000, 32'h08);
      rx_valid = 2'b01; rx_data = 16'h00AA;
      @(posedge clk); #1;
      rx_valid = 2'b00;
      cpu_read(16'h2000, rd);
      check("set beats clear", rd, 32'h0000_100F);
      for (int i = 0; i < 16; i++) begin
         cpu_read(16'h1000, rd);
         check($sformatf("rx drain %0d", i), rd, 32'(8'h60 + i));
      end
      cpu_read(16'h1000, rd);
      check("rx drained empty", rd, 32'h8000_0000);
      cpu_write(16'h2000, 32'h08);
      cpu_read(16'h2000, rd);
      check("ch0 idle status", rd, 32'h0000_0005);

      // TX full on ch0: push with same-cycle pop, then overflow
      for (int i = 0; i < 16; i++) cpu_write(16'h1000, 32'(8'h30 + i));
      cpu_read(16'h2000, rd);
      check("ch0 tx full", rd, 32'h0010_0000);
      cpu_write(16'h1000, 32'h99);
      tx_ready = 2'b01;
      @(posedge clk); #1;
      tx_ready = 2'b00;
      cpu_read(16'h2000, rd);
      check("push with pop accepted", rd, 32'h0010_0000);
      cpu_write(16'h1000, 32'hEE);
      cpu_read(16'h2000, rd);
      check("tx ovf", rd, 32'h0010_0010);
      @(posedge clk); #1;
      check("irq on tx ovf", 32'(irq), 32'h1);

      run_table(5, 9);

      // Mid-drain asynchronous reset
      tx_ready = 2'b01;
      @(negedge clk);
      check("drain head 0x31", 32'(tx_data[7:0]), 32'h31);
      @(negedge clk);
      check("drain head 0x32", 32'(tx_data[7:0]), 32'h32);
      #2 resetq = 1'b0;
      #1;
      check("async rst tx_valid", 32'(tx_valid), 32'h0);
      check("async rst tx_data", 32'(tx_data), 32'h0);
      check("async rst rx_ready", 32'(rx_ready), 32'h3);
      check("async rst irq", 32'(irq), 32'h0);
      tx_ready = 2'b00;
      @(negedge clk);
      resetq = 1'b1;
      @(posedge clk); #1;
      cpu_read(16'h2000, rd);
      check("status after mid reset", rd, 32'h0000_0005);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
